idli_sq_m: RTL and testbench

Issue sequencer for the nibble-serial execution unit. It generates the shared slot counter and tracks each instruction's lifecycle: first-word capture, immediate fetch, execute slot, and memory wait. It produces the run/capture enables that gate decode, register-file writeback and fetch. It sits between the memory fetch interface and the execution unit, and counts retired instructions.

---
 rtl/idli_sq_m.sv | 146 ++++++++++++++
 tb/tb_idli_sq_m.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/idli_sq_m.sv
// Issue sequencer for the nibble-serial execution unit.
// Generates the shared slot counter, walks each instruction through
// first-word capture, immediate fetch, execute and memory wait, and
// counts retired instructions. All state changes land on slot boundaries.
module idli_sq_m #(
  parameter int CTR_W = 2,
  parameter int RET_W = 16
) (
  input  logic             i_sq_gck,
  input  logic             i_sq_rst,
  input  logic             i_sq_enc_vld,
  input  logic             i_sq_need_imm,
  input  logic             i_sq_mem_op,
  input  logic             i_sq_mem_ack,
  input  logic             i_sq_redirect,
  output logic [CTR_W-1:0] o_sq_ctr,
  output logic             o_sq_run,
  output logic             o_sq_dec_en,
  output logic             o_sq_imm_en,
  output logic             o_sq_fetch_en,
  output logic             o_sq_flush,
  output logic [RET_W-1:0] o_sq_retired
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IMM  = 2'd1,
    ST_EXEC = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [CTR_W-1:0]   ctr_reg;
  logic [RET_W-1:0]   retired_reg;
  logic               flush_reg;
  logic               flush_next;
  logic               retire_next;
  logic               boundary;

  // Last cycle of the slot: the only cycle where decisions are taken.
  assign boundary = &ctr_reg;

  // Free-running slot counter; only reset stops it.
  always_ff @(posedge i_sq_gck) begin
    if (i_sq_rst) begin
      ctr_reg <= '0;
    end else begin
      ctr_reg <= ctr_reg + 1'b1;
    end
  end

  // Lifecycle state, flush pulse and retire count register together.
  always_ff @(posedge i_sq_gck) begin
    if (i_sq_rst) begin
      state_reg   <= ST_IDLE;
      flush_reg   <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      flush_reg <= flush_next;
      if (retire_next) begin
        retired_reg <= retired_reg + 1'b1;
      end
    end
  end

  // Boundary decisions: next state, flush request and retirement.
  always_comb begin
    state_next  = state_reg;
    flush_next  = 1'b0;
    retire_next = 1'b0;
    if (boundary) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (i_sq_enc_vld) begin
            state_next = i_sq_need_imm ? ST_IMM : ST_EXEC;
          end
        end
        ST_IMM: begin
          if (i_sq_enc_vld) begin
            state_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Memory op takes precedence; the word fetched meanwhile was
          // never requested because fetch was held off.
          if (i_sq_mem_op) begin
            state_next = ST_WAIT;
          end else if (i_sq_redirect) begin
            state_next  = ST_IDLE;
            flush_next  = 1'b1;
            retire_next = 1'b1;
          end else if (i_sq_enc_vld) begin
            state_next  = i_sq_need_imm ? ST_IMM : ST_EXEC;
            retire_next = 1'b1;
          end else begin
            state_next  = ST_IDLE;
            retire_next = 1'b1;
          end
        end
        ST_WAIT: begin
          if (i_sq_mem_ack) begin
            state_next  = ST_IDLE;
            retire_next = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Per-slot enables decoded from the current state.
  always_comb begin
    o_sq_run      = 1'b0;
    o_sq_dec_en   = 1'b0;
    o_sq_imm_en   = 1'b0;
    o_sq_fetch_en = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        o_sq_dec_en   = 1'b1;
        o_sq_fetch_en = 1'b1;
      end
      ST_IMM: begin
        o_sq_imm_en   = 1'b1;
        o_sq_fetch_en = 1'b1;
      end
      ST_EXEC: begin
        o_sq_run      = 1'b1;
        o_sq_dec_en   = 1'b1;
        o_sq_fetch_en = !i_sq_mem_op;
      end
      ST_WAIT: begin
        o_sq_run = 1'b0;
      end
      default: begin
        o_sq_run = 1'b0;
      end
    endcase
  end

  assign o_sq_ctr     = ctr_reg;
  assign o_sq_flush   = flush_reg;
  assign o_sq_retired = retired_reg;

endmodule

// File: tb/tb_idli_sq_m.sv
// Randomized bench for the issue sequencer against a slot-level reference
// model of instruction lifecycles (pending immediate, executing, waiting on
// memory). A narrow retire counter makes wrap-around happen often.
module tb_idli_sq_m;

  localparam int CTR_W = 2;
  localparam int RET_W = 4;
  localparam int SLOT  = 1 << CTR_W;
  localparam int NCYC  = 6000;

  logic             clk;
  logic             rst;
  logic             enc_vld;
  logic             need_imm;
  logic             mem_op;
  logic             mem_ack;
  logic             redirect;
  logic [CTR_W-1:0] ctr;
  logic             run;
  logic             dec_en;
  logic             imm_en;
  logic             fetch_en;
  logic             flush;
  logic [RET_W-1:0] retired;

  idli_sq_m #(.CTR_W(CTR_W), .RET_W(RET_W)) dut (
    .i_sq_gck      (clk),
    .i_sq_rst      (rst),
    .i_sq_enc_vld  (enc_vld),
    .i_sq_need_imm (need_imm),
    .i_sq_mem_op   (mem_op),
    .i_sq_mem_ack  (mem_ack),
    .i_sq_redirect (redirect),
    .o_sq_ctr      (ctr),
    .o_sq_run      (run),
    .o_sq_dec_en   (dec_en),
    .o_sq_imm_en   (imm_en),
    .o_sq_fetch_en (fetch_en),
    .o_sq_flush    (flush),
    .o_sq_retired  (retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycle count within slot, retirements so far, and which
  // lifecycle stage (if any) the current instruction occupies.
  int m_ctr;
  int m_ret;
  bit m_flush;
  bit m_wait_imm;
  bit m_exec;
  bit m_wait_mem;
  int m_total_retired;

  bit slot_mem_op;
  bit did_wait_rst;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic issue(input bit imm);
    if (imm) m_wait_imm = 1'b1;
    else     m_exec     = 1'b1;
  endtask

  task automatic retire_one(input int cyc);
    m_ret = (m_ret + 1) % (1 << RET_W);
    m_total_retired++;
    $display("retire #%0d cycle %0d count=%0d", m_total_retired, cyc, m_ret);
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_step(input int cyc);
    bit at_boundary;
    if (rst) begin
      m_ctr = 0; m_ret = 0; m_flush = 0;
      m_wait_imm = 0; m_exec = 0; m_wait_mem = 0;
      return;
    end
    at_boundary = (m_ctr == SLOT - 1);
    m_flush = 1'b0;
    if (at_boundary) begin
      if (m_wait_mem) begin
        if (mem_ack) begin
          m_wait_mem = 1'b0;
          retire_one(cyc);
        end
      end else if (m_wait_imm) begin
        if (enc_vld) begin
          m_wait_imm = 1'b0;
          m_exec     = 1'b1;
        end
      end else if (m_exec) begin
        m_exec = 1'b0;
        if (mem_op) begin
          m_wait_mem = 1'b1;
        end else if (redirect) begin
          m_flush = 1'b1;
          retire_one(cyc);
        end else begin
          retire_one(cyc);
          if (enc_vld) issue(need_imm);
        end
      end else if (enc_vld) begin
        issue(need_imm);
      end
    end
    m_ctr = (m_ctr + 1) % SLOT;
  endtask

  task automatic check_outputs();
    bit idle;
    idle = !(m_wait_imm || m_exec || m_wait_mem);
    check_val("ctr",      int'(ctr),      m_ctr);
    check_val("run",      int'(run),      int'(m_exec));
    check_val("dec_en",   int'(dec_en),   int'(idle || m_exec));
    check_val("imm_en",   int'(imm_en),   int'(m_wait_imm));
    check_val("fetch_en", int'(fetch_en), int'(idle || m_wait_imm || (m_exec && !mem_op)));
    check_val("flush",    int'(flush),    int'(m_flush));
    check_val("retired",  int'(retired),  m_ret);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    enc_vld = 0; need_imm = 0; mem_op = 0; mem_ack = 0; redirect = 0;
    slot_mem_op = 0; did_wait_rst = 0; m_total_retired = 0;
    m_ctr = 0; m_ret = 0; m_flush = 0; m_wait_imm = 0; m_exec = 0; m_wait_mem = 0;
    @(posedge clk);
    model_step(0);
    for (int cyc = 1; cyc < NCYC; cyc++) begin
      #1;
      rst = (cyc < 3) || ($urandom_range(0, 399) == 0);
      // Reset landing mid-slot during a memory wait.
      if (!did_wait_rst && cyc > 1000 && m_wait_mem && m_ctr == 2) begin
        rst = 1'b1;
        did_wait_rst = 1'b1;
      end
      // mem_op is a property of the executing instruction: hold it per slot.
      if (m_ctr == 0) slot_mem_op = ($urandom_range(0, 2) == 0);
      mem_op   = slot_mem_op;
      enc_vld  = ($urandom_range(0, 9) < 6);
      need_imm = ($urandom_range(0, 3) == 0);
      mem_ack  = ($urandom_range(0, 3) == 0);
      redirect = !slot_mem_op && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_step(cyc);
    end
    if (!did_wait_rst) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_reset: got 0 expected 1 (reset during WAIT never exercised)");
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
